// File: rtl/blinker_pkg.sv
// blinker_pkg: shared constants and types for the programmable blinker.
//   HALF_PERIOD_W     : width of the half-period register, in ticks
//   HALF_PERIOD_RESET : half-period loaded at reset
//   blink_pattern_e   : lamp pattern select encoding
package blinker_pkg;

  localparam int HALF_PERIOD_W     = 16;
  localparam int HALF_PERIOD_RESET = 15;

  // Encoding matches the i_is_flash_1 pin directly.
  typedef enum logic {
    FLASH2 = 1'b0,
    FLASH1 = 1'b1
  } blink_pattern_e;

endpackage

// File: rtl/blink_period_counter.sv
// blink_period_counter: owns the half-period H and the tick counter C.
//   i_clk          : system clock
//   i_reset        : synchronous active-high reset (H = HP_RST, C = 0)
//   i_shift_left   : halve H each clock while held (saturates at 1)
//   i_shift_right  : double H each clock while held (saturates when MSB set)
//   i_count_en     : tick strobe, advances C through 0..2H-1
//   o_half_period  : current H
//   o_count        : current C
module blink_period_counter
  import blinker_pkg::*;
#(
  parameter int HP_W   = HALF_PERIOD_W,
  parameter int HP_RST = HALF_PERIOD_RESET
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_shift_left,
  input  logic            i_shift_right,
  input  logic            i_count_en,
  output logic [HP_W-1:0] o_half_period,
  output logic [HP_W:0]   o_count
);

  logic [HP_W-1:0] r_half, w_half_nxt;
  logic [HP_W:0]   r_cnt, w_cnt_nxt, w_last;
  logic            w_h_chg;

  always_comb begin
    w_half_nxt = r_half;
    // Both commands together cancel; saturated steps leave H alone.
    if (i_shift_right && !i_shift_left && !r_half[HP_W-1])
      w_half_nxt = r_half << 1;
    else if (i_shift_left && !i_shift_right && (r_half != HP_W'(1)))
      w_half_nxt = r_half >> 1;

    w_h_chg = (w_half_nxt != r_half);
    w_last  = {r_half, 1'b0} - (HP_W+1)'(1);

    w_cnt_nxt = r_cnt;
    // A real rate change restarts the period at the top of an on-phase
    // and freezes counting for that clock.
    if (w_h_chg)
      w_cnt_nxt = '0;
    else if (i_count_en)
      w_cnt_nxt = (r_cnt == w_last) ? '0 : r_cnt + (HP_W+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_half <= HP_W'(HP_RST);
      r_cnt  <= '0;
    end else begin
      r_half <= w_half_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_half_period = r_half;
  assign o_count       = r_cnt;

endmodule

// File: rtl/programmable_blinker.sv
// programmable_blinker: tick-driven lamp blinker with programmable period.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_is_flash_1   : 1 = 50 % square flash, 0 = short-duty (25 %) flash
//   i_shift_left   : halve the half-period each clock held (faster)
//   i_shift_right  : double the half-period each clock held (slower)
//   i_count_en     : tick strobe
//   o_out          : registered lamp drive, one clock behind C/H
// Build option BLINKER_FLASH2_EN: when undefined the short-duty pattern is
// not built and i_is_flash_1 is ignored (always 50 % duty).
module programmable_blinker
  import blinker_pkg::*;
#(
  parameter int HP_W   = HALF_PERIOD_W,
  parameter int HP_RST = HALF_PERIOD_RESET
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_is_flash_1,
  input  logic i_shift_left,
  input  logic i_shift_right,
  input  logic i_count_en,
  output logic o_out
);

  logic [HP_W-1:0] w_half;
  logic [HP_W:0]   w_count;
  logic            w_flash1_on, w_on;
  logic            r_out;

  blink_period_counter #(
    .HP_W   (HP_W),
    .HP_RST (HP_RST)
  ) u_counter (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_shift_left  (i_shift_left),
    .i_shift_right (i_shift_right),
    .i_count_en    (i_count_en),
    .o_half_period (w_half),
    .o_count       (w_count)
  );

  assign w_flash1_on = (w_count < {1'b0, w_half});

`ifdef BLINKER_FLASH2_EN
  logic [HP_W-1:0] w_quarter;
  blink_pattern_e  w_pat;

  // H>>1 is 0 when H = 1; keep at least one tick of light.
  assign w_quarter = ((w_half >> 1) == '0) ? HP_W'(1) : (w_half >> 1);
  assign w_pat     = blink_pattern_e'(i_is_flash_1);
  assign w_on      = (w_pat == FLASH1) ? w_flash1_on
                                       : (w_count < {1'b0, w_quarter});
`else
  logic w_unused_flash_sel;
  assign w_unused_flash_sel = i_is_flash_1;
  assign w_on               = w_flash1_on;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_out <= 1'b0;
    else         r_out <= w_on;
  end

  assign o_out = r_out;

endmodule

// File: tb/tb_programmable_blinker.sv
module tb_programmable_blinker;

  logic clk = 1'b0;
  logic i_reset, i_is_flash_1, i_shift_left, i_shift_right, i_count_en;
  logic o_out;

  always #5 clk = ~clk;

  programmable_blinker dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_is_flash_1  (i_is_flash_1),
    .i_shift_left  (i_shift_left),
    .i_shift_right (i_shift_right),
    .i_count_en    (i_count_en),
    .o_out         (o_out)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // stimulus knobs
  logic g_rst = 1'b1, g_fl = 1'b1, g_sl = 1'b0, g_sr = 1'b0;
  int   en_period = 10;
  int   tick_ph   = 0;

  // reference model state
  logic [15:0] mH = 16'd15;
  int          mC = 0;

  logic sb[$];

  // Scoreboard: one expected o_out per clock, compared after the edge.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      logic e;
      e = sb.pop_front();
      n_chk++;
      if (o_out !== e) begin
        n_fail++;
        $display("FAIL sb_out t=%0t got %b want %b", $time, o_out, e);
      end
    end
  end

  // Drive one clock at the negedge, step the model, push expectation,
  // return just after the following posedge.
  task automatic cyc();
    logic        en, exp_out;
    logic [15:0] nH;
    int          q;
    @(negedge clk);
    en = (tick_ph == 0);
    i_reset = g_rst; i_is_flash_1 = g_fl; i_shift_left = g_sl;
    i_shift_right = g_sr; i_count_en = en;
    if (g_rst) begin
      mH = 16'd15; mC = 0; exp_out = 1'b0; tick_ph = 0;
    end else begin
`ifdef BLINKER_FLASH2_EN
      q = (mH >> 1 == 0) ? 1 : int'(mH >> 1);
      exp_out = g_fl ? (mC < int'(mH)) : (mC < q);
`else
      q = 0;
      exp_out = (mC < int'(mH));
`endif
      nH = mH;
      if (g_sr && !g_sl && !mH[15]) nH = mH << 1;
      else if (g_sl && !g_sr && mH != 16'd1) nH = mH >> 1;
      if (nH != mH) mC = 0;
      else if (en) mC = (mC == 2*int'(mH) - 1) ? 0 : mC + 1;
      mH = nH;
      tick_ph = (tick_ph + 1) % en_period;
    end
    sb.push_back(exp_out);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int ep);
    en_period = ep;
    g_rst = 1'b1; g_sl = 1'b0; g_sr = 1'b0;
    cyc(); cyc();
    g_rst = 1'b0;
  endtask

  // Length of one full low run followed by one full high run.
  task automatic measure_runs(output int hi, output int lo, output bit tmo);
    int n;
    tmo = 0; hi = 0; lo = 0; n = 0;
    while (o_out !== 1'b1 && n < 5000) begin cyc(); n++; end
    while (o_out !== 1'b0 && n < 5000) begin cyc(); n++; end
    while (o_out === 1'b0 && lo < 5000) begin cyc(); lo++; end
    while (o_out === 1'b1 && hi < 5000) begin cyc(); hi++; end
    if (n >= 5000 || lo >= 5000 || hi >= 5000) tmo = 1;
  endtask

  task automatic check_runs(string nm, int hi, int lo, bit tmo, int ehi, int elo);
    n_chk++;
    if (tmo || hi != ehi || lo != elo) begin
      n_fail++;
      $display("FAIL %s hi=%0d lo=%0d tmo=%0d want hi=%0d lo=%0d", nm, hi, lo, tmo, ehi, elo);
    end
  endtask

  task automatic test_reset();
    int hi, lo; bit tmo;
    g_fl = 1'b1;
    do_reset(10);
    n_chk++;
    if (o_out !== 1'b0) begin n_fail++; $display("FAIL reset_out got %b want 0", o_out); end
    cyc();
    n_chk++;
    if (o_out !== 1'b1) begin n_fail++; $display("FAIL first_on got %b want 1", o_out); end
    measure_runs(hi, lo, tmo);
    check_runs("flash1_h15", hi, lo, tmo, 150, 150);
  endtask

  task automatic test_shift_right();
    int hi, lo; bit tmo;
    do_reset(10);
    repeat (37) cyc();
    g_sr = 1'b1; cyc(); cyc(); g_sr = 1'b0;
    n_chk++;
    if (dut.u_counter.r_half !== 16'd60 || dut.u_counter.r_cnt !== 17'd0) begin
      n_fail++;
      $display("FAIL sr2 H=%0d C=%0d want H=60 C=0", dut.u_counter.r_half, dut.u_counter.r_cnt);
    end
    measure_runs(hi, lo, tmo);
    check_runs("flash1_h60", hi, lo, tmo, 600, 600);
  endtask

  task automatic test_saturation();
    int hi, lo; bit tmo;
    do_reset(1);
    g_sl = 1'b1; repeat (20) cyc(); g_sl = 1'b0;
    n_chk++;
    if (dut.u_counter.r_half !== 16'd1) begin
      n_fail++; $display("FAIL sat_left H=%0d want 1", dut.u_counter.r_half);
    end
    measure_runs(hi, lo, tmo);
    check_runs("h1_period2", hi, lo, tmo, 1, 1);
    do_reset(1);
    g_sr = 1'b1; repeat (20) cyc(); g_sr = 1'b0;
    n_chk++;
    if (dut.u_counter.r_half !== 16'hF000) begin
      n_fail++; $display("FAIL sat_right H=%h want f000", dut.u_counter.r_half);
    end
    repeat (50) cyc();
  endtask

  task automatic test_both_shifts();
    int hi, lo; bit tmo;
    do_reset(10);
    repeat (73) cyc();
    g_sl = 1'b1; g_sr = 1'b1; repeat (5) cyc(); g_sl = 1'b0; g_sr = 1'b0;
    n_chk++;
    if (dut.u_counter.r_half !== 16'd15 || mC != 8) begin
      n_fail++;
      $display("FAIL both_shift H=%0d modelC=%0d want H=15 C=8", dut.u_counter.r_half, mC);
    end
    measure_runs(hi, lo, tmo);
    check_runs("both_phase", hi, lo, tmo, 150, 150);
  endtask

  task automatic test_flash2();
    int hi, lo; bit tmo;
    g_fl = 1'b0;
    do_reset(1);
    measure_runs(hi, lo, tmo);
`ifdef BLINKER_FLASH2_EN
    check_runs("flash2_h15", hi, lo, tmo, 7, 23);
`else
    check_runs("flash2_off", hi, lo, tmo, 15, 15);
`endif
    // switch back mid-period without disturbing C/H
    repeat (11) cyc();
    g_fl = 1'b1;
    repeat (40) cyc();
  endtask

  task automatic test_reset_mid();
    do_reset(10);
    g_sr = 1'b1; cyc(); cyc(); g_sr = 1'b0;
    repeat (300) cyc();
    g_rst = 1'b1; g_sl = 1'b1; i_count_en = 1'b1;
    cyc();
    g_rst = 1'b0; g_sl = 1'b0;
    n_chk++;
    if (dut.u_counter.r_half !== 16'd15 || dut.u_counter.r_cnt !== 17'd0 || o_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid H=%0d C=%0d out=%b want 15 0 0",
               dut.u_counter.r_half, dut.u_counter.r_cnt, o_out);
    end
    repeat (30) cyc();
  endtask

  initial begin
    i_reset = 1'b1; i_is_flash_1 = 1'b1; i_shift_left = 1'b0;
    i_shift_right = 1'b0; i_count_en = 1'b0;
    test_reset();
    test_shift_right();
    test_saturation();
    test_both_shifts();
    test_flash2();
    test_reset_mid();
    @(posedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/programmable_blinker.md
# programmable_blinker

Tick-driven lamp blinker for the bike-light datapath. It counts `count_en` strobes (typically `beat32`) and drives a single lamp output with a programmable blink period. The period is doubled or halved one step per clock by `shift_right` / `shift_left`. A pattern select chooses between a 50 % square flash and a short-duty flash.

## Interface
- `HALF_PERIOD_W`, 16: width of the half-period register, in ticks.
- `HALF_PERIOD_RESET`, 15: half-period loaded at reset (full period 30 ticks = 3 µs at a 100 ns tick).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `is_flash_1`  in  1  pattern select: 1 = flash 1 (50 % duty), 0 = flash 2 (short duty).
- `shift_left`  in  1  level command, evaluated every clock: halve the half-period (faster blink).
- `shift_right`  in  1  level command, evaluated every clock: double the half-period (slower blink).
- `count_en`  in  1  one-clock tick strobe; advances the blink counter.
- `out`  out  1  registered lamp drive.

## Operation
- State:
  - `half_period` H (HALF_PERIOD_W bits, never 0).
  - Tick counter C, range 0..2H−1.
  - `out` flop.
- Reset: H = HALF_PERIOD_RESET, C = 0, `out` = 0.
- Shift commands:
  - Evaluated every clock while asserted, independent of `count_en`. Holding a command for N clocks applies N steps.
  - `shift_right` alone: H ← H<<1. Saturates: no change if H[MSB] = 1.
  - `shift_left` alone: H ← H>>1. Saturates: no change if H = 1.
  - Both asserted: no change, and C is not cleared.
  - Any step that actually changes H also clears C to 0 in that clock, so the new rate starts at the beginning of an on-phase.
  - A saturated (no-op) step leaves C untouched.
- Counting:
  - With no H change this clock and `count_en` = 1: C ← (C == 2H−1) ? 0 : C+1.
  - `count_en` = 0: C holds.
  - Counting is frozen in a clock where H changes.
- Pattern (next `out`, computed from the current C and H):
  - Flash 1 (`is_flash_1` = 1): `out` ← (C < H).
  - Flash 2 (`is_flash_1` = 0): `out` ← (C < max(1, H>>1)), i.e. a 25 % duty pulse at the start of each period.
- `is_flash_1` may change at any time; it takes effect on the next clock without disturbing C or H.

## Timing
- `out` has exactly one clock of latency from C/H. First clock after reset release: `out` = 0. The following clock: `out` = 1, since C = 0 < H.
- Blink period = 2H `count_en` ticks:
  - Reset default: 30 ticks.
  - With `count_en` every 10 clocks: 300 clocks = 3 µs at 100 MHz.
- A command held for 2 clocks after reset gives H = 60, i.e. 120 ticks = 12 µs.
- Reset mid-operation overrides all inputs in that clock.

## Configuration
- `BLINKER_FLASH2_EN` defined: flash-2 pattern built; `is_flash_1` selects the pattern as above.
- Not defined: flash-2 logic removed; `is_flash_1` is ignored and `out` always follows the flash-1 (50 %) pattern.

## Structure
- Shared package `blinker_pkg` holds `HALF_PERIOD_W`, `HALF_PERIOD_RESET`, and a `blink_pattern_e` enum (FLASH1, FLASH2).
- One sub-module, `blink_period_counter`, owns H, C, the shift/saturation logic, and wrap. The top holds pattern decode and the `out` flop.

## Test plan
- Reset with `count_en` every 10th clock, no shifts: `out` goes high 1 clock after reset, then toggles with 150 clocks high / 150 low (flash 1).
- `shift_right` held 2 clocks: H = 60; `out` gives 600 clocks high / 600 low; C restarts at 0.
- `shift_left` held 20 clocks from reset: H saturates at 1, giving a period of 2 ticks; `shift_right` held 20 clocks from reset saturates at H[15] = 1.
- Both shifts asserted for 5 clocks: H and C unchanged; blink phase is undisturbed.
- `is_flash_1` = 0 with H = 15: `out` is high for 7 ticks and low for 23 ticks per 30-tick period. Without `BLINKER_FLASH2_EN` it stays 15/15.
- Reset asserted mid-period with H = 60: the next clock gives H = 15, C = 0, `out` = 0.
